// File: rtl/hazard_unit.sv
// Hazard controller for the five-stage MIPS pipeline: operand forwarding,
// load-use/branch/mult-div stall detection and a saturating stall counter.
module hazard_unit #(
  parameter int unsigned MD_LATENCY     = 32,
  parameter int unsigned STALLCNT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [4:0]                rsD,
  input  logic [4:0]                rtD,
  input  logic [4:0]                rsE,
  input  logic [4:0]                rtE,
  input  logic [4:0]                writeregE,
  input  logic [4:0]                writeregM,
  input  logic [4:0]                writeregW,
  input  logic                      regwriteE,
  input  logic                      regwriteM,
  input  logic                      regwriteW,
  input  logic                      memtoregE,
  input  logic                      memtoregM,
  input  logic                      branchD,
  input  logic                      mdstartD,
  input  logic                      mdstartE,
  input  logic                      mfhiloD,
  output logic [1:0]                forwardAE,
  output logic [1:0]                forwardBE,
  output logic                      forwardAD,
  output logic                      forwardBD,
  output logic                      stallF,
  output logic                      stallD,
  output logic                      flushE,
  output logic                      mdbusy,
  output logic [STALLCNT_WIDTH-1:0] stallcnt
);

  localparam int unsigned CntW = $clog2(MD_LATENCY + 1);

  typedef enum logic [0:0] {StIdle, StBusy} md_state_e;

  md_state_e                 state_q, state_d;
  logic [CntW-1:0]           cnt_q, cnt_d;
  logic [STALLCNT_WIDTH-1:0] stallcnt_q, stallcnt_d;

  logic m_valid, w_valid, e_valid;
  logic lwstall, branchstall, mdstall, stall;

  // $0 is hardwired to zero, so a write to it is never a real producer.
  assign m_valid = regwriteM && (writeregM != 5'd0);
  assign w_valid = regwriteW && (writeregW != 5'd0);
  assign e_valid = regwriteE && (writeregE != 5'd0);

  always_comb begin
    forwardAE = 2'b00;
    forwardBE = 2'b00;
    if (m_valid && (writeregM == rsE))      forwardAE = 2'b10;
    else if (w_valid && (writeregW == rsE)) forwardAE = 2'b01;
    if (m_valid && (writeregM == rtE))      forwardBE = 2'b10;
    else if (w_valid && (writeregW == rtE)) forwardBE = 2'b01;
  end

  assign forwardAD = m_valid && (writeregM == rsD);
  assign forwardBD = m_valid && (writeregM == rtD);

  always_comb begin
    lwstall     = memtoregE && (rtE != 5'd0) && ((rtE == rsD) || (rtE == rtD));
    branchstall = branchD &&
                  ((e_valid && ((writeregE == rsD) || (writeregE == rtD))) ||
                   (memtoregM && (writeregM != 5'd0) &&
                    ((writeregM == rsD) || (writeregM == rtD))));
    mdstall     = (mdbusy || mdstartE) && (mfhiloD || mdstartD);
    stall       = lwstall || branchstall || mdstall;
  end

  assign stallF = stall;
  assign stallD = stall;
  assign flushE = stall;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (mdstartE) begin
          state_d = StBusy;
          cnt_d   = CntW'(MD_LATENCY - 1);
        end
      end
      StBusy: begin
        // A second issue while busy is ignored; legal flow stalls it in D.
        if (cnt_q == '0) state_d = StIdle;
        else             cnt_d   = cnt_q - CntW'(1);
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    stallcnt_d = stallcnt_q;
    if (stall && !(&stallcnt_q)) stallcnt_d = stallcnt_q + STALLCNT_WIDTH'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      stallcnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      stallcnt_q <= stallcnt_d;
    end
  end

  assign mdbusy   = (state_q == StBusy);
  assign stallcnt = stallcnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit with a rule-level reference model checked every cycle.
module tb_hazard_unit;

  localparam int unsigned LAT = 4;
  localparam int unsigned SW  = 4;
  localparam int          SAT = (1 << SW) - 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [4:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
  logic regwriteE, regwriteM, regwriteW, memtoregE, memtoregM;
  logic branchD, mdstartD, mdstartE, mfhiloD;
  logic [1:0] forwardAE, forwardBE;
  logic forwardAD, forwardBD, stallF, stallD, flushE, mdbusy;
  logic [SW-1:0] stallcnt;

  int checks = 0;
  int errors = 0;

  // Model state: cycles of busy time still ahead, and the stall count as an integer.
  int busy_rem = 0;
  int scnt = 0;

  hazard_unit #(.MD_LATENCY(LAT), .STALLCNT_WIDTH(SW)) dut (
    .clk(clk), .reset(reset),
    .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
    .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
    .memtoregE(memtoregE), .memtoregM(memtoregM),
    .branchD(branchD), .mdstartD(mdstartD), .mdstartE(mdstartE), .mfhiloD(mfhiloD),
    .forwardAE(forwardAE), .forwardBE(forwardBE),
    .forwardAD(forwardAD), .forwardBD(forwardBD),
    .stallF(stallF), .stallD(stallD), .flushE(flushE),
    .mdbusy(mdbusy), .stallcnt(stallcnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int fwd_e(input logic [4:0] src);
    if (regwriteM && writeregM != 0 && writeregM == src) return 2;
    if (regwriteW && writeregW != 0 && writeregW == src) return 1;
    return 0;
  endfunction

  function automatic int model_stall();
    bit lw, br, md;
    bit e_hit, m_hit;
    lw = memtoregE && rtE != 0 && (rtE == rsD || rtE == rtD);
    e_hit = regwriteE && writeregE != 0 && (writeregE == rsD || writeregE == rtD);
    m_hit = memtoregM && writeregM != 0 && (writeregM == rsD || writeregM == rtD);
    br = branchD && (e_hit || m_hit);
    md = (busy_rem > 0 || mdstartE) && (mfhiloD || mdstartD);
    return int'(lw || br || md);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_rem <= 0;
      scnt     <= 0;
    end else begin
      if (busy_rem > 0)  busy_rem <= busy_rem - 1;
      else if (mdstartE) busy_rem <= LAT;
      if (model_stall() != 0 && scnt < SAT) scnt <= scnt + 1;
    end
  end

  always @(negedge clk) begin
    int s;
    s = model_stall();
    chk("forwardAE", int'(forwardAE), fwd_e(rsE));
    chk("forwardBE", int'(forwardBE), fwd_e(rtE));
    chk("forwardAD", int'(forwardAD), int'(regwriteM && writeregM != 0 && writeregM == rsD));
    chk("forwardBD", int'(forwardBD), int'(regwriteM && writeregM != 0 && writeregM == rtD));
    chk("stallF", int'(stallF), s);
    chk("stallD", int'(stallD), s);
    chk("flushE", int'(flushE), s);
    chk("mdbusy", int'(mdbusy), int'(busy_rem > 0));
    chk("stallcnt", int'(stallcnt), scnt);
  end

  task automatic idle_inputs();
    rsD = 0; rtD = 0; rsE = 0; rtE = 0;
    writeregE = 0; writeregM = 0; writeregW = 0;
    regwriteE = 0; regwriteM = 0; regwriteW = 0;
    memtoregE = 0; memtoregM = 0;
    branchD = 0; mdstartD = 0; mdstartE = 0; mfhiloD = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle_inputs();
    repeat (2) step();
    chk("rst_mdbusy", int'(mdbusy), 0);
    chk("rst_stallcnt", int'(stallcnt), 0);
    reset = 1'b0;
    step();

    // Forwarding, A then B side.
    rsE = 8; regwriteM = 1; writeregM = 8; #1;
    chk("fwdA_m", int'(forwardAE), 2);
    regwriteW = 1; writeregW = 8; #1;
    chk("fwdA_m_over_w", int'(forwardAE), 2);
    regwriteM = 0; #1;
    chk("fwdA_w", int'(forwardAE), 1);
    step();
    regwriteM = 1; writeregM = 0; writeregW = 0; rsE = 0; #1;
    chk("fwdA_zero", int'(forwardAE), 0);
    step();
    idle_inputs(); rtE = 8; regwriteM = 1; writeregM = 8; #1;
    chk("fwdB_m", int'(forwardBE), 2);
    regwriteW = 1; writeregW = 8; #1;
    chk("fwdB_m_over_w", int'(forwardBE), 2);
    regwriteM = 0; #1;
    chk("fwdB_w", int'(forwardBE), 1);
    step();
    regwriteM = 1; writeregM = 0; writeregW = 0; rtE = 0; #1;
    chk("fwdB_zero", int'(forwardBE), 0);
    step();

    // Load-use.
    idle_inputs(); memtoregE = 1; rtE = 9; rsD = 9; #1;
    chk("lw_stall", int'(stallF), 1);
    chk("lw_flush", int'(flushE), 1);
    step();
    idle_inputs(); #1;
    chk("lw_cnt", int'(stallcnt), 1);
    chk("lw_released", int'(stallD), 0);
    memtoregE = 1; rtE = 0; rsD = 0; #1;
    chk("lw_r0", int'(stallF), 0);
    step();

    // Branch compare hazards.
    idle_inputs(); branchD = 1; regwriteE = 1; writeregE = 10; rsD = 10; #1;
    chk("br_alu_e", int'(stallF), 1);
    step();
    idle_inputs(); branchD = 1; memtoregM = 1; writeregM = 11; rtD = 11; #1;
    chk("br_load_m", int'(stallF), 1);
    step();
    idle_inputs(); branchD = 1; regwriteM = 1; writeregM = 12; rsD = 12; #1;
    chk("br_fwd_ad", int'(forwardAD), 1);
    chk("br_fwd_nostall", int'(stallF), 0);
    step();
    idle_inputs(); #1;
    chk("cnt_after_br", int'(stallcnt), 3);

    // Mult/div with and without a dependent mfhi/mflo.
    for (int pass = 0; pass < 2; pass++) begin
      mdstartE = 1; mfhiloD = (pass == 0);
      for (int c = 0; c <= int'(LAT) + 1; c++) begin
        #1;
        chk("md_stall", int'(stallF), int'(pass == 0 && c <= int'(LAT)));
        chk("md_busy", int'(mdbusy), int'(c >= 1 && c <= int'(LAT)));
        step();
        mdstartE = 0;
      end
      idle_inputs();
    end

    // Reset between edges during BUSY.
    mdstartE = 1; mfhiloD = 1;
    step();
    mdstartE = 0;
    step();
    #2;
    reset = 1'b1; #1;
    chk("rstmid_busy", int'(mdbusy), 0);
    chk("rstmid_cnt", int'(stallcnt), 0);
    chk("rstmid_stall", int'(stallF), 0);
    step();
    #2 reset = 1'b0;
    step();
    chk("post_rst_stall", int'(stallF), 0);
    chk("post_rst_busy", int'(mdbusy), 0);
    step();
    idle_inputs();

    // Saturation.
    memtoregE = 1; rtE = 9; rsD = 9;
    repeat (20) step();
    chk("sat_15", int'(stallcnt), SAT);
    repeat (3) step();
    chk("sat_hold", int'(stallcnt), SAT);
    idle_inputs();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
